// File: rtl/cdc_hs_src_ctrl.sv
// Source side of a 4-phase req/ack clock-domain crossing. It holds one payload word,
// raises xfer_req, waits for the synchronized ack edges and reports done or a timeout error.
module cdc_hs_src_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic             clk_a,
    input  logic             rst_a,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    // state  | meaning
    // IDLE   | waiting for a word; in_ready high once out of reset
    // REQ_HI | xfer_req high, waiting for ack_s to rise
    // REQ_LO | xfer_req low, waiting for ack_s to fall
    // ERR    | an ack edge timed out; waits for err_clr with ack_s low
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic        TMO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t state, state_nxt;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync;

    logic        ack_s;
    logic [15:0] tmo_cnt;
    logic        started;
    logic        accept;
    logic        tmo_hit;
    logic        done_nxt;

    always_ff @(posedge clk_a or negedge rst_a) begin
        if (!rst_a) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // started keeps in_ready low until the first edge after reset release
    assign in_ready = started && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);

    // Exit conditions are tested before the timeout so a coincident ack edge wins.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_nxt = REQ_LO;
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                end
            end
            ERR: begin
                if (err_clr && !ack_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_a or negedge rst_a) begin
        if (!rst_a) begin
            state     <= IDLE;
            started   <= 1'b0;
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            started  <= 1'b1;
            xfer_req <= (state_nxt == REQ_HI);
            done     <= done_nxt;
            err      <= (state_nxt == ERR);
            if (accept) begin
                xfer_data <= in_data;
            end
            if (state_nxt != state) begin
                tmo_cnt <= '0;
            end else if (state == REQ_HI || state == REQ_LO) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// Bench for cdc_hs_src_ctrl: the bench plays the destination domain and predicts
// handshake latency, timeout and done counts from the ack delays it chooses.
module tb_cdc_hs_src_ctrl;

    localparam int W    = 32;
    localparam int SYNC = 2;
    localparam int TMO  = 8;

    logic         clk_a    = 1'b0;
    logic         rst_a    = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         xfer_ack = 1'b0;
    logic         err_clr  = 1'b0;
    logic         in_ready;
    logic         xfer_req;
    logic [W-1:0] xfer_data;
    logic         done;
    logic         err;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int dly_hi   = 0;
    int dly_lo   = 0;
    int resp_cnt = 0;
    bit ack_never = 1'b0;
    bit ack_stuck = 1'b0;

    always #5 clk_a = ~clk_a;

    cdc_hs_src_ctrl #(
        .WIDTH      (W),
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_a    (clk_a),
        .rst_a    (rst_a),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .xfer_req (xfer_req),
        .xfer_data(xfer_data),
        .xfer_ack (xfer_ack),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then act as the destination.
    // The destination raises ack dly_hi falling edges after seeing req high and
    // drops it dly_lo falling edges after seeing req low.
    task automatic step();
        @(negedge clk_a);
        if (done) done_cnt++;
        if (xfer_req && !xfer_ack && !ack_never) begin
            if (resp_cnt >= dly_hi) begin
                xfer_ack = 1'b1;
                resp_cnt = 0;
            end else begin
                resp_cnt++;
            end
        end else if (!xfer_req && xfer_ack && !ack_stuck) begin
            if (resp_cnt >= dly_lo) begin
                xfer_ack = 1'b0;
                resp_cnt = 0;
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_cnt = 0;
        end
    endtask

    // Falling edges from acceptance to the first done sample: two synchronizer
    // traversals plus one edge to drop req and one edge to enter IDLE.
    function automatic int exp_done_step(input int dh, input int dl);
        return 2 * SYNC + 2 + dh + dl;
    endfunction

    task automatic send(input logic [W-1:0] word, input int dh, input int dl, input string tag);
        int lat;
        int d0;
        lat    = -1;
        d0     = done_cnt;
        dly_hi = dh;
        dly_lo = dl;
        chk({tag, "_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = word;
        step();
        in_valid = 1'b0;
        in_data  = $urandom();
        chk({tag, "_req_rise"}, xfer_req, 1'b1);
        chk({tag, "_data"}, xfer_data, word);
        chk({tag, "_busy"}, in_ready, 1'b0);
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            step();
            chk({tag, "_hold"}, xfer_data, word);
            chk({tag, "_req"}, xfer_req, (i < dh + SYNC + 1));
            chk({tag, "_noerr"}, err, 1'b0);
            if (done) lat = i;
        end
        chk({tag, "_latency"}, lat, exp_done_step(dh, dl));
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        step();
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [W-1:0] words [3];
        logic [W-1:0] word;
        logic [W-1:0] prev;
        int           idx;
        int           d0;
        int           k;
        bit           acc;
        bit           was_done;

        // reset: outputs forced before any clock edge
        #2 rst_a = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_req", xfer_req, 1'b0);
        chk("rst_data", xfer_data, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        step();
        step();
        rst_a = 1'b1;
        chk("rel_ready_pre", in_ready, 1'b0);
        step();
        chk("rel_ready_post", in_ready, 1'b1);

        // single word, destination acks one cycle after seeing req
        send(32'hA5A5_0001, 1, 1, "single");
        chk("single_total_done", done_cnt, 1);

        // err_clr outside ERR has no effect
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_idle_err", err, 1'b0);
        chk("clr_idle_ready", in_ready, 1'b1);

        // back-to-back with in_valid held high
        words[0] = 32'h1;
        words[1] = 32'h2;
        words[2] = 32'h3;
        dly_hi   = 0;
        dly_lo   = 0;
        idx      = 0;
        d0       = done_cnt;
        prev     = xfer_data;
        in_valid = 1'b1;
        in_data  = words[0];
        for (int c = 0; c < 100 && idx < 3; c++) begin
            acc      = in_ready && in_valid;
            was_done = done;
            step();
            if (acc) begin
                chk("b2b_data", xfer_data, words[idx]);
                if (idx > 0) chk("b2b_acc_in_done", was_done, 1'b1);
                idx++;
                if (idx == 3) in_valid = 1'b0;
                else in_data = words[idx];
            end else begin
                chk("b2b_hold", xfer_data, prev);
            end
            prev = xfer_data;
        end
        chk("b2b_accepted", idx, 3);
        for (int c = 0; c < 40 && (done_cnt - d0) < 3; c++) step();
        for (int c = 0; c < 4; c++) step();
        chk("b2b_done_cnt", done_cnt - d0, 3);
        chk("b2b_last_data", xfer_data, 32'h3);

        // timeout with ack never rising
        ack_never = 1'b1;
        d0        = done_cnt;
        word      = 32'hDEAD_0008;
        in_valid  = 1'b1;
        in_data   = word;
        step();
        in_valid = 1'b0;
        chk("toh_req0", xfer_req, 1'b1);
        for (int i = 1; i <= TMO + 3; i++) begin
            step();
            chk("toh_req", xfer_req, (i < TMO));
            chk("toh_err", err, (i >= TMO));
            chk("toh_data", xfer_data, word);
            if (i >= TMO) chk("toh_ready", in_ready, 1'b0);
        end
        ack_never = 1'b0;
        err_clr   = 1'b1;
        step();
        err_clr = 1'b0;
        chk("toh_clr_err", err, 1'b0);
        chk("toh_clr_ready", in_ready, 1'b1);
        chk("toh_no_done", done_cnt - d0, 0);

        // timeout with ack stuck high in REQ_LO
        dly_hi    = 0;
        ack_stuck = 1'b1;
        d0        = done_cnt;
        word      = 32'h0BAD_5111;
        in_valid  = 1'b1;
        in_data   = word;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= SYNC + 1 + TMO; i++) begin
            step();
            chk("tol_err", err, (i >= SYNC + 1 + TMO));
            chk("tol_req", xfer_req, (i < SYNC + 1));
        end
        err_clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tol_clr_ignored", err, 1'b1);
            chk("tol_ready", in_ready, 1'b0);
        end
        ack_stuck = 1'b0;
        dly_lo    = 0;
        k         = -1;
        for (int i = 1; i <= 20 && k < 0; i++) begin
            step();
            if (!err) k = i;
        end
        err_clr = 1'b0;
        chk("tol_clr_step", k, SYNC + 2);
        chk("tol_idle_ready", in_ready, 1'b1);
        chk("tol_data", xfer_data, word);
        chk("tol_no_done", done_cnt - d0, 0);

        // ack_s rises in the timeout cycle: the exit wins
        send(32'h7E57_0001, TMO - 1 - SYNC, 0, "tie");

        // randomized traffic; err_clr noise must be ignored
        for (int t = 0; t < 20; t++) begin
            int gap;
            word    = $urandom();
            gap     = $urandom_range(0, 3);
            err_clr = 1'($urandom_range(0, 1));
            send(word, $urandom_range(0, 4), $urandom_range(0, 4), "rnd");
            err_clr = 1'b0;
            for (int g = 0; g < gap; g++) begin
                step();
                chk("rnd_gap_ready", in_ready, 1'b1);
                chk("rnd_gap_req", xfer_req, 1'b0);
                chk("rnd_gap_data", xfer_data, word);
            end
        end

        // reset during REQ_LO abandons the transfer
        dly_hi    = 0;
        ack_stuck = 1'b1;
        d0        = done_cnt;
        word      = 32'hC0DE_0042;
        in_valid  = 1'b1;
        in_data   = word;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < SYNC + 1; i++) step();
        chk("mid_in_reqlo", xfer_req, 1'b0);
        chk("mid_data_pre", xfer_data, word);
        #2 rst_a = 1'b0;
        #1;
        chk("mid_req", xfer_req, 1'b0);
        chk("mid_data", xfer_data, '0);
        chk("mid_ready", in_ready, 1'b0);
        chk("mid_done", done, 1'b0);
        ack_stuck = 1'b0;
        xfer_ack  = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_a = 1'b1;
        chk("mid_rel_ready_pre", in_ready, 1'b0);
        step();
        chk("mid_rel_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) step();
        chk("mid_no_done", done_cnt - d0, 0);

        send(32'h600D_0001, 0, 2, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_hs_src_ctrl.md
CDC_HS_SRC_CTRL -- requirements
Module: cdc_hs_src_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits.
REQ-002 Parameter SYNC_STAGES, default 2: flops in the internal xfer_ack synchronizer; legal range 2..4.
REQ-003 Parameter TIMEOUT, default 0: maximum cycles to wait for an ack edge; 0 disables the timeout; legal range 0..65535.
REQ-004 clk_a  in  1: source-domain clock; the only clock in the block.
REQ-005 rst_a  in  1: asynchronous, active-low reset.
REQ-006 in_valid  in  1: local requester has a word to send.
REQ-007 in_data  in  WIDTH: word to send, sampled on acceptance.
REQ-008 in_ready  out  1: block can accept a word.
REQ-009 xfer_req  out  1: 4-phase request to the destination domain; driven directly from a flop.
REQ-010 xfer_data  out  WIDTH: held payload to the destination domain; driven directly from a flop.
REQ-011 xfer_ack  in  1: 4-phase acknowledge, asynchronous to clk_a.
REQ-012 done  out  1: one-cycle pulse when a handshake completes.
REQ-013 err  out  1: timeout error flag; sticky until cleared.
REQ-014 err_clr  in  1: request to clear err.

Function
REQ-015 xfer_ack SHALL pass through a SYNC_STAGES flop chain (ASYNC_REG="TRUE", reset to 0) to produce ack_s; no other logic SHALL use raw xfer_ack.
REQ-016 FSM states SHALL be IDLE, REQ_HI, REQ_LO and ERR.
REQ-017 in_ready SHALL be 1 only in IDLE; acceptance occurs when in_valid && in_ready.
REQ-018 On acceptance, xfer_data SHALL load in_data, xfer_req SHALL rise on the next clk_a edge, and the state SHALL move to REQ_HI.
REQ-019 xfer_data SHALL hold its value from acceptance until the next acceptance, with no change at any point in REQ_HI, REQ_LO or ERR.
REQ-020 In REQ_HI with ack_s==1, xfer_req SHALL drop at the next edge and the state SHALL move to REQ_LO.
REQ-021 In REQ_LO with ack_s==0, the state SHALL move to IDLE and done SHALL be 1 for exactly one cycle, in the first IDLE cycle.
REQ-022 Minimum cycles from acceptance to done: 2*SYNC_STAGES+3, when the destination acks instantly.
REQ-023 A new word SHALL be acceptable in the same cycle that done is 1.
REQ-024 Timeout counter (16 bits) SHALL clear on entry to REQ_HI or REQ_LO and increment each cycle while in that state.
REQ-025 With TIMEOUT!=0, when the counter equals TIMEOUT-1 and the exit condition is false, the next state SHALL be ERR, err SHALL be set and xfer_req SHALL be 0.
REQ-026 If the exit condition and the timeout occur in the same cycle, the exit condition SHALL win and err SHALL stay 0.
REQ-027 In ERR, in_ready SHALL be 0 and xfer_req SHALL be 0.
REQ-028 In ERR, err_clr==1 with ack_s==0 SHALL clear err and return to IDLE; with ack_s==1, the state SHALL stay ERR and err SHALL remain 1.
REQ-029 err_clr SHALL be ignored outside ERR.
REQ-030 done SHALL never assert on a path through ERR.

Reset
REQ-031 While rst_a==0, outputs SHALL be forced immediately, without waiting for a clock edge, to: in_ready=0, xfer_req=0, xfer_data=0, done=0, err=0; the state SHALL be IDLE and the sync chain and counter SHALL be 0.
REQ-032 in_ready SHALL rise on the first clk_a edge after rst_a deasserts.
REQ-033 Reset asserted mid-handshake SHALL abandon the transfer: xfer_req=0 immediately and no done pulse.

Verification
REQ-034 Bench SHALL cover these directed scenarios:
- Single word: in_data=0xA5A5_0001, dest acks 1 cycle after seeing req -> xfer_data=0xA5A5_0001 stable throughout; done once; xfer_req high then low.
- Back-to-back: 3 words 0x1, 0x2, 0x3 with in_valid held high -> each accepted in its done cycle; xfer_data sequence 1, 2, 3; exactly 3 done pulses.
- Timeout high: TIMEOUT=8, ack never rises -> err=1 and xfer_req=0 on the cycle after 8 REQ_HI cycles; in_ready=0.
- Timeout low: TIMEOUT=8, ack stuck high -> ERR entered; err_clr ignored until ack falls; then IDLE with err=0.
- Tie: ack_s rises in the exact timeout cycle -> REQ_LO entered, err=0.
- Mid-op reset: rst_a=0 during REQ_LO -> xfer_req=0 and xfer_data=0 asynchronously; no done; in_ready=1 one edge after release.
